// File: rtl/regfile_bus_master_if.sv
// Command, response and register-file bus signals of regfile_bus_master.
// The master modport is the initiator's view; the slave modport is everything on the far side.
interface regfile_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] addr;
    logic              chip_select;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              data_valid;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        input  rsp_ready, read_data, data_valid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output addr, chip_select, write_en, read_en, write_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        output rsp_ready, read_data, data_valid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  addr, chip_select, write_en, read_en, write_data
    );
endinterface

// File: rtl/regfile_bus_master.sv
// Single-command bus initiator: runs READ / WRITE / masked RMW as single-beat
// register-file transfers and returns one response per accepted command.
module regfile_bus_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_bus_master_if.master  bus,
    output logic                  busy
);
    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RMW     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RMW_WR,
        S_RESP
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e            state;
    op_e               op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [7:0]        wait_cnt;

    // NOTE: every register here uses <= so all state advances together at the edge;
    // the asynchronous reset branch is what makes strobes drop the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            op_q            <= OP_READ;
            wdata_q         <= '0;
            mask_q          <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.addr        <= '0;
            bus.chip_select <= 1'b0;
            bus.write_en    <= 1'b0;
            bus.read_en     <= 1'b0;
            bus.write_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready is high throughout IDLE, so cmd_valid alone is the accept.
                    if (bus.cmd_valid) begin
                        op_q          <= op_e'(bus.cmd_op);
                        wdata_q       <= bus.cmd_wdata;
                        mask_q        <= bus.cmd_mask;
                        bus.addr      <= bus.cmd_addr;
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (bus.cmd_addr[1:0] != 2'b00 || op_e'(bus.cmd_op) == OP_ILLEGAL) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else if (op_e'(bus.cmd_op) == OP_WRITE) begin
                            state           <= S_WRITE;
                            bus.chip_select <= 1'b1;
                            bus.write_en    <= 1'b1;
                            bus.write_data  <= bus.cmd_wdata;
                        end else begin
                            state           <= S_READ;
                            bus.chip_select <= 1'b1;
                            bus.read_en     <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    state           <= S_RESP;
                    bus.chip_select <= 1'b0;
                    bus.write_en    <= 1'b0;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_err     <= 1'b0;
                    bus.rsp_rdata   <= '0;
                end

                S_READ: begin
                    if (bus.data_valid) begin
                        // The pre-modify sample is parked in rsp_rdata; rsp_valid qualifies it later.
                        bus.read_en   <= 1'b0;
                        bus.rsp_rdata <= bus.read_data;
                        if (op_q == OP_RMW) begin
                            state          <= S_RMW_WR;
                            bus.write_en   <= 1'b1;
                            bus.write_data <= (bus.read_data & ~mask_q) | (wdata_q & mask_q);
                        end else begin
                            state           <= S_RESP;
                            bus.chip_select <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_err     <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            state           <= S_RESP;
                            bus.chip_select <= 1'b0;
                            bus.read_en     <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_err     <= 1'b1;
                            bus.rsp_rdata   <= '0;
                        end
                    end
                end

                S_RMW_WR: begin
                    state           <= S_RESP;
                    bus.chip_select <= 1'b0;
                    bus.write_en    <= 1'b0;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_err     <= 1'b0;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_bus_master.sv
// Bench for regfile_bus_master: a register-file slave with wait states/stall, a
// transaction-level model that predicts each response, and directed command vectors.
module tb_regfile_bus_master;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    regfile_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register-file slave ----------------
    logic        slave_rst_n;
    logic        slave_stall;
    logic        dv_force;
    int          wait_states;
    int          wait_seen;
    logic [31:0] slave_mem [64];

    assign bus.read_data  = slave_mem[bus.addr[7:2]];
    assign bus.data_valid = (bus.chip_select & bus.read_en & ~slave_stall & (wait_seen >= wait_states))
                          | dv_force;

    always @(posedge clk or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            for (int i = 0; i < 64; i++) slave_mem[i] <= (i == 5) ? 32'h0000_AA55 : 32'h0;
            wait_seen <= 0;
        end else begin
            if (bus.chip_select && bus.write_en) slave_mem[bus.addr[7:2]] <= bus.write_data;
            if (bus.chip_select && bus.read_en && !bus.data_valid) wait_seen <= wait_seen + 1;
            else wait_seen <= 0;
        end
    end

    // ---------------- transaction model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_re;
        int          n_we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    logic [31:0] ref_mem [64];

    function automatic exp_t predict(input logic [1:0] op, input logic [7:0] a,
                                     input logic [31:0] wd, input logic [31:0] mk);
        exp_t e;
        int   w;
        w       = int'(a[7:2]);
        e.addr  = a;
        e.wdata = 32'h0;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.n_re  = 0;
        e.n_we  = 0;
        if (a[1:0] != 2'b00 || op == 2'b11) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (op == 2'b01) begin
            e.lat     = 2;
            e.n_we    = 1;
            e.wdata   = wd;
            ref_mem[w] = wd;
        end else if (slave_stall || wait_states >= TIMEOUT) begin
            e.err  = 1'b1;
            e.lat  = TIMEOUT + 1;
            e.n_re = TIMEOUT;
        end else begin
            e.n_re  = wait_states + 1;
            e.rdata = ref_mem[w];
            if (op == 2'b00) begin
                e.lat = 2 + wait_states;
            end else begin
                e.lat      = 3 + wait_states;
                e.n_we     = 1;
                e.wdata    = (ref_mem[w] & ~mk) | (wd & mk);
                ref_mem[w] = e.wdata;
            end
        end
        return e;
    endfunction

    task automatic reset_check(input string name);
        check({name, "_ctl"},
              {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.chip_select, bus.write_en, bus.read_en, busy},
              7'b100_0000);
        check({name, "_data"}, {bus.rsp_rdata, bus.addr, bus.write_data}, '0);
    endtask

    // Compare process: one look per cycle at the falling edge.
    initial begin : compare
        exp_t        e;
        bit          active;
        bit          seen;
        int          cyc, n_re, n_we;
        logic [31:0] held_rdata;
        logic        held_err;
        active = 0;
        seen   = 0;
        cyc = 0; n_re = 0; n_we = 0;
        held_rdata = '0;
        held_err   = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 5) ? 32'h0000_AA55 : 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                seen   = 0;
                reset_check("rst_state");
                continue;
            end
            check("bus_invariant",
                  {bus.read_en & bus.write_en,
                   (bus.read_en | bus.write_en) & ~bus.chip_select,
                   bus.rsp_valid & bus.chip_select,
                   bus.cmd_ready & bus.chip_select,
                   bus.cmd_ready == busy}, 5'b0);
            check("busy", busy, active);
            if (active) begin
                cyc++;
                if (bus.read_en) n_re++;
                if (bus.write_en) begin
                    n_we++;
                    check("write_data", bus.write_data, e.wdata);
                end
                if (bus.chip_select) check("bus_addr", bus.addr, e.addr);
                if (bus.rsp_valid) begin
                    if (!seen) begin
                        seen = 1;
                        check("rsp_latency", cyc, e.lat);
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_err", bus.rsp_err, e.err);
                        check("read_strobes", n_re, e.n_re);
                        check("write_strobes", n_we, e.n_we);
                        held_rdata = bus.rsp_rdata;
                        held_err   = bus.rsp_err;
                    end else begin
                        check("rsp_stable", {bus.rsp_err, bus.rsp_rdata}, {held_err, held_rdata});
                    end
                    if (bus.rsp_ready) active = 0;
                end
            end else begin
                check("no_stray_rsp", bus.rsp_valid, 1'b0);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                e      = predict(bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, bus.cmd_mask);
                active = 1;
                seen   = 0;
                cyc = 0; n_re = 0; n_we = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_cmd(input logic [1:0] op, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] mk);
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_mask  = mk;
    endtask

    // Returns the number of rising edges until the command was taken (accepting one included).
    task automatic wait_accept(output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_accepted", got, 1'b1);
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                got = 1'b1;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
            end
        end
        check("rsp_arrived", got, 1'b1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd,
                          input logic [31:0] mk, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        set_cmd(op, a, wd, mk);
        bus.cmd_valid = 1'b1;
        wait_accept(n);
        bus.cmd_valid = 1'b0;
        wait_rsp(rd, er, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        int          stray;
        int          mism;

        rst_n           = 1'b0;
        slave_rst_n     = 1'b0;
        slave_stall     = 1'b0;
        dv_force        = 1'b0;
        wait_states     = 0;
        bus.cmd_valid   = 1'b0;
        bus.rsp_ready   = 1'b1;
        set_cmd(2'b00, 8'h00, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        reset_check("por");
        rst_n       = 1'b1;
        slave_rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_check("idle_after_release");

        // Plain write, then a read of the slave's reset contents.
        do_cmd(2'b01, 8'h00, 32'h5, 32'h0, rd, er, lat);
        check("wr_lat", lat, 2);
        check("wr_rsp", {er, rd}, {1'b0, 32'h0});
        check("wr_slave", slave_mem[0], 32'h5);

        do_cmd(2'b00, 8'h14, 32'h0, 32'h0, rd, er, lat);
        check("rd_lat", lat, 2);
        check("rd_rsp", {er, rd}, {1'b0, 32'h0000_AA55});

        // RMW: old 0x7, mask 0x6, new 0x4 -> 0x5 written back.
        do_cmd(2'b01, 8'h00, 32'h7, 32'h0, rd, er, lat);
        do_cmd(2'b10, 8'h00, 32'h4, 32'h6, rd, er, lat);
        check("rmw_lat", lat, 3);
        check("rmw_rsp", {er, rd}, {1'b0, 32'h7});
        check("rmw_slave", slave_mem[0], 32'h5);

        // Wait-stated slave.
        wait_states = 3;
        do_cmd(2'b00, 8'h00, 32'h0, 32'h0, rd, er, lat);
        check("rd_wait_lat", lat, 5);
        check("rd_wait_rsp", rd, 32'h5);
        wait_states = 1;
        do_cmd(2'b10, 8'h14, 32'h1234_0000, 32'hFFFF_0000, rd, er, lat);
        check("rmw_wait_lat", lat, 4);
        check("rmw_wait_slave", slave_mem[5], 32'h1234_AA55);
        wait_states = 0;

        // Timeout: data_valid never comes.
        slave_stall = 1'b1;
        do_cmd(2'b00, 8'h08, 32'h0, 32'h0, rd, er, lat);
        check("timeout_lat", lat, 16);
        check("timeout_rsp", {er, rd}, {1'b1, 32'h0});
        slave_stall = 1'b0;

        // Rejected commands: misaligned read, illegal op, misaligned write.
        do_cmd(2'b00, 8'h03, 32'h0, 32'h0, rd, er, lat);
        check("misalign_rd", {er, 8'(lat)}, {1'b1, 8'd1});
        do_cmd(2'b11, 8'h04, 32'hDEAD, 32'hFFFF, rd, er, lat);
        check("illegal_op", {er, 8'(lat)}, {1'b1, 8'd1});
        do_cmd(2'b01, 8'h02, 32'hBAD, 32'h0, rd, er, lat);
        check("misalign_wr", {er, 8'(lat), slave_mem[0]}, {1'b1, 8'd1, 32'h5});

        // Stray data_valid outside READ changes nothing.
        dv_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stray_dv_idle", {busy, bus.cmd_ready}, 2'b01);
        do_cmd(2'b01, 8'h10, 32'hCAFE_F00D, 32'h0, rd, er, lat);
        dv_force = 1'b0;
        check("stray_dv_write", slave_mem[4], 32'hCAFE_F00D);

        // Response back-pressure with the next command already waiting.
        bus.rsp_ready = 1'b0;
        set_cmd(2'b00, 8'h10, 32'h0, 32'h0);
        bus.cmd_valid = 1'b1;
        wait_accept(n);
        set_cmd(2'b01, 8'h18, 32'h11, 32'h0);
        wait_rsp(rd, er, lat);
        check("bp_rsp", rd, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_cmd_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b01);
        end
        bus.rsp_ready = 1'b1;
        wait_accept(n);
        check("bp_next_accept", n, 2);
        bus.cmd_valid = 1'b0;
        wait_rsp(rd, er, lat);
        check("bp_next_lat", lat, 2);
        @(posedge clk);
        #1;
        check("bp_next_slave", slave_mem[6], 32'h11);

        // Reset while an RMW sits in its read phase.
        slave_stall = 1'b1;
        set_cmd(2'b10, 8'h00, 32'hFF, 32'hFF);
        bus.cmd_valid = 1'b1;
        wait_accept(n);
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rmw_in_read", {bus.chip_select, bus.read_en}, 2'b11);
        rst_n = 1'b0;
        #1;
        reset_check("mid_op_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        slave_stall = 1'b0;
        stray       = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        check("no_rsp_after_reset", stray, 0);
        reset_check("idle_after_mid_reset");
        check("rmw_abandoned", slave_mem[0], 32'h5);

        mism = 0;
        for (int i = 0; i < 64; i++) if (slave_mem[i] !== ref_mem[i]) mism++;
        check("mem_final", mism, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
